sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_pkg.sv | 26 ++
 rtl/sram_controller_if.sv | 21 ++
 rtl/sram_controller.sv | 92 +++++++++
 tb/tb_sram_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit CPU to 16-bit asynchronous SRAM bridge.
package sram_controller_pkg;

  localparam int unsigned CPU_DW          = 32;
  localparam int unsigned CPU_AW          = 32;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned SRAM_AW         = 18;
  localparam int unsigned WIDX_W          = SRAM_AW - 1;
  localparam int unsigned CNT_W           = 3;
  localparam int unsigned HALF_CYCLES_DEF = 2;
  localparam logic [CPU_AW-1:0] BASE_ADDR_DEF = 32'd1024;

  typedef enum logic [1:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    DONE
  } state_e;

  // Offset from the window base, reduced to a 32-bit word index (bits [18:2], wraps mod 2^19).
  function automatic logic [WIDX_W-1:0] word_index(input logic [CPU_AW-1:0] addr,
                                                   input logic [CPU_AW-1:0] base);
    return WIDX_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// CPU MEM-stage request/response bundle between the pipeline and the SRAM bridge.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic              wrEn;
  logic              rdEn;
  logic [CPU_AW-1:0] address;
  logic [CPU_DW-1:0] writeData;
  logic [CPU_DW-1:0] readData;
  logic              ready;

  modport master (
    output wrEn, rdEn, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  wrEn, rdEn, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit CPU load/store into two timed 16-bit SRAM accesses (low half, then high half).
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned       HALF_CYCLES = HALF_CYCLES_DEF,
  parameter logic [CPU_AW-1:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   cpu,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [SRAM_DW-1:0] sramDqOut,
  input  logic [SRAM_DW-1:0] sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN,
  output logic               sramOeN
);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                op_wr_q;
  logic [WIDX_W-1:0]   widx_q;
  logic [CPU_DW-1:0]   data_q;
  logic [CPU_DW-1:0]   rdata_q;
  logic [SRAM_AW-1:0]  sram_addr_q;

  logic cnt_last_c;
  logic acc_c;
  logic req_c;

  assign cnt_last_c = (cnt_q == CNT_W'(HALF_CYCLES - 1));
  assign acc_c      = (state_q == ACC_LO) || (state_q == ACC_HI);
  assign req_c      = cpu.wrEn || cpu.rdEn;

  // Sequencer: IDLE -> ACC_LO -> ACC_HI -> DONE -> IDLE, each access half lasting HALF_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      widx_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_c) begin
            op_wr_q     <= cpu.wrEn;
            widx_q      <= word_index(cpu.address, BASE_ADDR);
            data_q      <= cpu.writeData;
            sram_addr_q <= {word_index(cpu.address, BASE_ADDR), 1'b0};
            cnt_q       <= '0;
            state_q     <= ACC_LO;
          end
        end
        ACC_LO: begin
          if (cnt_last_c) begin
            cnt_q       <= '0;
            state_q     <= ACC_HI;
            sram_addr_q <= {widx_q, 1'b1};
            if (!op_wr_q) rdata_q[SRAM_DW-1:0] <= sramDqIn;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ACC_HI: begin
          if (cnt_last_c) begin
            cnt_q   <= '0;
            state_q <= DONE;
            if (!op_wr_q) rdata_q[CPU_DW-1:SRAM_DW] <= sramDqIn;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // SRAM strobes depend only on registered state; the last cycle of each half is the write hold cycle.
  assign sramAddr  = sram_addr_q;
  assign sramDqOut = (state_q == ACC_HI) ? data_q[CPU_DW-1:SRAM_DW] : data_q[SRAM_DW-1:0];
  assign sramDqOe  = acc_c && op_wr_q;
  assign sramWeN   = !(acc_c && op_wr_q && !cnt_last_c);
  assign sramOeN   = !(acc_c && !op_wr_q);

  assign cpu.readData = rdata_q;
  assign cpu.ready    = (state_q == DONE) || ((state_q == IDLE) && !req_c);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM on the data bus.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut;
  logic [15:0] sramDqIn;
  logic        sramDqOe;
  logic        sramWeN;
  logic        sramOeN;

  sram_controller_if cpu_if ();

  sram_controller #(.HALF_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu_if),
    .sramAddr  (sramAddr),
    .sramDqOut (sramDqOut),
    .sramDqIn  (sramDqIn),
    .sramDqOe  (sramDqOe),
    .sramWeN   (sramWeN),
    .sramOeN   (sramOeN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  always @(posedge clk) if (!sramWeN) mem[sramAddr[7:0]] <= sramDqOut;
  assign sramDqIn = sramOeN ? 16'h0000 : mem[sramAddr[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  int          lat, nw, noe, ndqoe;
  logic [17:0] wa [4];
  logic [15:0] wd [4];

  // Presents one request from the IDLE cycle (k=0) and samples strobes each negedge until ready.
  task automatic issue(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
    lat = -1; nw = 0; noe = 0; ndqoe = 0;
    @(posedge clk); #1;
    cpu_if.wrEn = wr; cpu_if.rdEn = rd; cpu_if.address = addr; cpu_if.writeData = data;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!sramWeN) begin
        if (nw < 4) begin wa[nw] = sramAddr; wd[nw] = sramDqOut; end
        nw++;
      end
      if (!sramOeN) noe++;
      if (sramDqOe) ndqoe++;
      if (cpu_if.ready) begin lat = k; break; end
    end
    cpu_if.wrEn = 1'b0; cpu_if.rdEn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_if.wrEn = 1'b0; cpu_if.rdEn = 1'b0; cpu_if.address = '0; cpu_if.writeData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cpu_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cpu_if.ready); end
    n_checks++; if (cpu_if.readData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", cpu_if.readData); end
    n_checks++; if (sramAddr !== 18'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", sramAddr); end
    n_checks++; if (sramWeN !== 1'b1) begin n_fail++; $display("FAIL reset_wen got %b exp 1", sramWeN); end
    n_checks++; if (sramOeN !== 1'b1) begin n_fail++; $display("FAIL reset_oen got %b exp 1", sramOeN); end
    n_checks++; if (sramDqOe !== 1'b0) begin n_fail++; $display("FAIL reset_dqoe got %b exp 0", sramDqOe); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_write();
    issue(1'b1, 1'b0, 32'd1024, 32'h12345678);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wr_latency got %0d exp 5", lat); end
    n_checks++; if (nw !== 2) begin n_fail++; $display("FAIL wr_wen_cycles got %0d exp 2", nw); end
    n_checks++; if (wa[0] !== 18'd0 || wd[0] !== 16'h5678) begin n_fail++; $display("FAIL wr_lo got %h/%h exp 0/5678", wa[0], wd[0]); end
    n_checks++; if (wa[1] !== 18'd1 || wd[1] !== 16'h1234) begin n_fail++; $display("FAIL wr_hi got %h/%h exp 1/1234", wa[1], wd[1]); end
    n_checks++; if (ndqoe !== 4) begin n_fail++; $display("FAIL wr_dqoe_cycles got %0d exp 4", ndqoe); end
    n_checks++; if (noe !== 0) begin n_fail++; $display("FAIL wr_oen_cycles got %0d exp 0", noe); end
    @(negedge clk);
    n_checks++; if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin n_fail++; $display("FAIL wr_mem got %h %h exp 5678 1234", mem[0], mem[1]); end
    n_checks++; if (cpu_if.readData !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_hold got %h exp 0", cpu_if.readData); end
  endtask

  task automatic test_read();
    issue(1'b0, 1'b1, 32'd1024, 32'h0);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rd_latency got %0d exp 5", lat); end
    n_checks++; if (cpu_if.readData !== 32'h12345678) begin n_fail++; $display("FAIL rd_data got %h exp 12345678", cpu_if.readData); end
    n_checks++; if (noe !== 4 || nw !== 0) begin n_fail++; $display("FAIL rd_strobes got oe=%0d we=%0d exp 4 0", noe, nw); end
    repeat (3) @(negedge clk);
    n_checks++; if (cpu_if.readData !== 32'h12345678) begin n_fail++; $display("FAIL rd_data_hold got %h exp 12345678", cpu_if.readData); end
    n_checks++; if (sramAddr !== 18'd1) begin n_fail++; $display("FAIL idle_addr_hold got %h exp 1", sramAddr); end
  endtask

  task automatic test_addr_map();
    issue(1'b1, 1'b0, 32'd1028, 32'hAABBCCDD);
    n_checks++; if (wa[0] !== 18'd2 || wd[0] !== 16'hCCDD) begin n_fail++; $display("FAIL map_lo got %h/%h exp 2/ccdd", wa[0], wd[0]); end
    n_checks++; if (wa[1] !== 18'd3 || wd[1] !== 16'hAABB) begin n_fail++; $display("FAIL map_hi got %h/%h exp 3/aabb", wa[1], wd[1]); end
  endtask

  task automatic test_both();
    issue(1'b1, 1'b1, 32'd1032, 32'h0BADF00D);
    n_checks++; if (noe !== 0) begin n_fail++; $display("FAIL both_oen got %0d exp 0", noe); end
    n_checks++; if (nw !== 2) begin n_fail++; $display("FAIL both_wen got %0d exp 2", nw); end
    @(negedge clk);
    n_checks++; if (mem[4] !== 16'hF00D || mem[5] !== 16'h0BAD) begin n_fail++; $display("FAIL both_mem got %h %h exp f00d 0bad", mem[4], mem[5]); end
    n_checks++; if (cpu_if.readData !== 32'h12345678) begin n_fail++; $display("FAIL both_rdata got %h exp 12345678", cpu_if.readData); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cpu_if.rdEn = 1'b1; cpu_if.address = 32'd1028;
    repeat (4) @(negedge clk);
    n_checks++; if (cpu_if.readData !== 32'h1234CCDD) begin n_fail++; $display("FAIL mid_partial got %h exp 1234ccdd", cpu_if.readData); end
    rst = 1'b1; cpu_if.rdEn = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_if.ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b exp 1", cpu_if.ready); end
    n_checks++; if (cpu_if.readData !== 32'h0) begin n_fail++; $display("FAIL mid_rdata got %h exp 0", cpu_if.readData); end
    n_checks++; if (sramOeN !== 1'b1 || sramWeN !== 1'b1 || sramDqOe !== 1'b0) begin n_fail++; $display("FAIL mid_strobes got oe=%b we=%b dq=%b exp 1 1 0", sramOeN, sramWeN, sramDqOe); end
    n_checks++; if (sramAddr !== 18'h0) begin n_fail++; $display("FAIL mid_addr got %h exp 0", sramAddr); end
    rst = 1'b0;
    issue(1'b0, 1'b1, 32'd1024, 32'h0);
    n_checks++; if (lat !== 5 || cpu_if.readData !== 32'h12345678) begin n_fail++; $display("FAIL post_reset_rd got lat=%0d data=%h exp 5 12345678", lat, cpu_if.readData); end
  endtask

  task automatic test_back_to_back();
    int s1, s2, d1, d2;
    logic r_after;
    s1 = -1; s2 = -1; d1 = -1; d2 = -1; r_after = 1'bx;
    @(posedge clk); #1;
    cpu_if.wrEn = 1'b1; cpu_if.rdEn = 1'b0; cpu_if.address = 32'd1036; cpu_if.writeData = 32'h11112222;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sramDqOe && s1 < 0) s1 = k;
      if (!sramOeN && s2 < 0) s2 = k;
      if (d1 >= 0 && k == d1 + 1) r_after = cpu_if.ready;
      if (cpu_if.ready && k > 0) begin
        if (d1 < 0) begin
          d1 = k; cpu_if.wrEn = 1'b0; cpu_if.rdEn = 1'b1;
        end else if (k > d1) begin
          d2 = k; break;
        end
      end
    end
    cpu_if.wrEn = 1'b0; cpu_if.rdEn = 1'b0;
    n_checks++; if (d1 !== 5) begin n_fail++; $display("FAIL b2b_first_done got %0d exp 5", d1); end
    n_checks++; if (r_after !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ready got %b exp 0", r_after); end
    n_checks++; if (s2 - s1 !== 6) begin n_fail++; $display("FAIL b2b_start_gap got %0d exp 6", s2 - s1); end
    n_checks++; if (d2 - s1 !== 10) begin n_fail++; $display("FAIL b2b_span got %0d exp 10", d2 - s1); end
    n_checks++; if (cpu_if.readData !== 32'h11112222) begin n_fail++; $display("FAIL b2b_rdata got %h exp 11112222", cpu_if.readData); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_write();
    test_read();
    test_addr_map();
    test_both();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
